// File: rtl/fft_helpers_bit_reverse_stream.sv
// rtl/fft_helpers_bit_reverse_stream.sv - streaming bit-reversal reorder buffer with ping-pong banks
// Samples are written at bitrev(index) and read out linearly, so output m carries input bitrev(m).
module fft_helpers_bit_reverse_stream #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] send_msg
);
    localparam int IW = $clog2(N_SAMPLES);
    localparam logic [IW-1:0] LAST = IW'(N_SAMPLES - 1);

    logic [BIT_WIDTH-1:0] mem [2][N_SAMPLES];
    logic [1:0]           full;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [IW-1:0]        wr_idx;
    logic [IW-1:0]        rd_idx;
    logic                 wr_fire;
    logic                 rd_fire;

    function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        for (int i = 0; i < IW; i++) begin
            r[i] = v[IW-1-i];
        end
        return r;
    endfunction

    // Ready depends only on state so upstream never sees a combinational path from send_rdy.
    assign recv_rdy = !full[wr_bank];
    assign send_val = full[rd_bank];
    assign send_msg = send_val ? mem[rd_bank][rd_idx] : '0;
    assign wr_fire  = recv_val && recv_rdy;
    assign rd_fire  = send_val && send_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N_SAMPLES; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else begin
            // The write bank is empty and the read bank is full, so the two
            // flag updates below always target different banks.
            if (wr_fire) begin
                mem[wr_bank][bitrev(wr_idx)] <= recv_msg;
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
            if (rd_fire) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_idx == LAST) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_helpers_bit_reverse_stream.sv
// tb/tb_fft_helpers_bit_reverse_stream.sv - directed and randomized bench with a frame-level reference model
module tb_fft_helpers_bit_reverse_stream;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        recv_val = 1'b0;
    logic        recv_rdy;
    logic [31:0] recv_msg = '0;
    logic        send_val;
    logic        send_rdy = 1'b0;
    logic [31:0] send_msg;

    logic        rv2 = 1'b0, rr2, sv2, sr2 = 1'b0;
    logic [31:0] rm2 = '0, sm2;
    logic        rv32 = 1'b0, rr32, sv32, sr32 = 1'b0;
    logic [31:0] rm32 = '0, sm32;

    int checks = 0;
    int errors = 0;
    int waited;
    bit prod_done;
    logic [31:0] in_frame[$];
    logic [31:0] exp_q[$];
    logic [31:0] got[$];
    logic [31:0] got2[$];
    logic [31:0] got32[$];
    logic [31:0] held;

    always #5 clk = ~clk;

    fft_helpers_bit_reverse_stream #(.BIT_WIDTH(32), .N_SAMPLES(N)) dut (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg));
    fft_helpers_bit_reverse_stream #(.BIT_WIDTH(32), .N_SAMPLES(2)) dut_n2 (
        .clk(clk), .reset(reset), .recv_val(rv2), .recv_rdy(rr2), .recv_msg(rm2),
        .send_val(sv2), .send_rdy(sr2), .send_msg(sm2));
    fft_helpers_bit_reverse_stream #(.BIT_WIDTH(32), .N_SAMPLES(32)) dut_n32 (
        .clk(clk), .reset(reset), .recv_val(rv32), .recv_rdy(rr32), .recv_msg(rm32),
        .send_val(sv32), .send_rdy(sr32), .send_msg(sm32));

    function automatic int brev(input int m, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) r = r * 2 + ((m >> b) & 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: collect accepted samples into frames; a complete frame yields out[m] = in[bitrev(m)].
    always @(negedge clk) begin
        if (reset) begin
            in_frame.delete();
            exp_q.delete();
        end else begin
            if (send_val && send_rdy) begin
                got.push_back(send_msg);
                chk("out_expected_avail", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) chk("out_data", send_msg, exp_q.pop_front());
            end
            if (recv_val && recv_rdy) begin
                in_frame.push_back(recv_msg);
                if (in_frame.size() == N) begin
                    for (int m = 0; m < N; m++) exp_q.push_back(in_frame[brev(m, 3)]);
                    in_frame.delete();
                end
            end
            if (sv2 && sr2) got2.push_back(sm2);
            if (sv32 && sr32) got32.push_back(sm32);
        end
    end

    task automatic push(input logic [31:0] d, output int w);
        recv_val = 1'b1;
        recv_msg = d;
        w = 0;
        while (!recv_rdy && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 200) chk("push_timeout", w, 0);
        else begin
            @(posedge clk); #1;
        end
        recv_val = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        send_rdy = 1'b1;
        while ((exp_q.size() != 0 || send_val) && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_exp_empty", exp_q.size(), 0);
        chk("drain_send_val", {31'b0, send_val}, 0);
    endtask

    initial begin
        logic [31:0] t1_exp[8];
        logic [31:0] t5_exp[8];
        t1_exp = '{10, 14, 12, 16, 11, 15, 13, 17};
        t5_exp = '{0, 4, 2, 6, 1, 5, 3, 7};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_recv_rdy", {31'b0, recv_rdy}, 1);
        chk("rst_send_val", {31'b0, send_val}, 0);
        chk("rst_send_msg", send_msg, 0);

        // Single frame, latency of one cycle after the last input.
        got.delete();
        send_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            push(32'(10 + i), waited);
            chk("t1_send_val", {31'b0, send_val}, {31'b0, i == N - 1});
        end
        drain();
        chk("t1_count", got.size(), N);
        for (int m = 0; m < N && m < got.size(); m++) chk("t1_order", got[m], t1_exp[m]);

        // Three back-to-back frames at full rate.
        got.delete();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) begin
                recv_val = 1'b1;
                recv_msg = 32'((f + 1) * 10 + i);
                chk("t2_recv_rdy", {31'b0, recv_rdy}, 1);
                @(posedge clk); #1;
            end
        end
        recv_val = 1'b0;
        drain();
        chk("t2_count", got.size(), 3 * N);

        // Backpressure: both banks fill, then space returns after one bank drains.
        send_rdy = 1'b0;
        for (int i = 0; i < 2 * N; i++) push(32'(100 + i), waited);
        chk("t3_recv_rdy_full", {31'b0, recv_rdy}, 0);
        held = send_msg;
        chk("t3_first_out", held, 100);
        repeat (3) @(posedge clk);
        #1 chk("t3_stall_stable", send_msg, held);
        send_rdy = 1'b1;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk); #1;
            chk("t3_recv_rdy_drain", {31'b0, recv_rdy}, {31'b0, k == N});
        end
        drain();

        // Random valid/ready over 50 frames.
        got.delete();
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 50 * N; i++) begin
                    int gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                    push($urandom, waited);
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    send_rdy = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        chk("t4_count", got.size(), 50 * N);

        // Mid-frame reset discards the partial frame.
        for (int i = 0; i < 5; i++) push(32'(50 + i), waited);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5_recv_rdy", {31'b0, recv_rdy}, 1);
        chk("t5_send_val", {31'b0, send_val}, 0);
        chk("t5_send_msg", send_msg, 0);
        got.delete();
        for (int i = 0; i < N; i++) push(32'(i), waited);
        drain();
        chk("t5_count", got.size(), N);
        for (int m = 0; m < N && m < got.size(); m++) chk("t5_order", got[m], t5_exp[m]);

        // Other frame lengths: single ramp frame each.
        sr2 = 1'b1;
        sr32 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rv2 = (i < 2);
            rm2 = 32'(i);
            rv32 = 1'b1;
            rm32 = 32'(i);
            @(posedge clk); #1;
        end
        rv2 = 1'b0;
        rv32 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("n2_count", got2.size(), 2);
        for (int m = 0; m < 2 && m < got2.size(); m++) chk("n2_order", got2[m], 32'(m));
        chk("n32_count", got32.size(), 32);
        for (int m = 0; m < 32 && m < got32.size(); m++) chk("n32_order", got32[m], 32'(brev(m, 5)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
